// File: rtl/proto_pkg.sv
// Shared types and constants for the protocol sequencer and its buffers.
package proto_pkg;

    localparam int unsigned DATA_W = 4;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_e;

    // Command buffer entry: direction plus write data.
    typedef struct packed {
        logic              rw;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head entry is visible combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/proto_sequencer.sv
// Queues read/write commands, issues them one at a time to the master/slave top
// with a fixed transfer window, and buffers returned read data in command order.
module proto_sequencer
    import proto_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned XFER_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     start,
    output logic                     rw_out,
    output logic [DATA_W-1:0]        m_data_out,
    input  logic [DATA_W-1:0]        m_rcvd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(XFER_CYCLES);

    seq_state_e       state;
    logic [CNT_W-1:0] cnt;

    cmd_t             cmd_in;
    cmd_t             cmd_head;
    logic             cmd_empty;
    logic             cmd_push;
    logic             cmd_pop;

    logic             rsp_empty;
    logic [CW-1:0]    rsp_count;
    logic             rsp_full;
    logic             rsp_push;
    logic             rsp_pop;

    assign cmd_in    = '{rw: cmd_rw, data: cmd_data};
    assign cmd_ready = (cmd_count != CW'(DEPTH));
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_pop   = (state == ST_IDLE) && !cmd_empty;

    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_ready && rsp_valid;
    assign rsp_full  = (rsp_count == CW'(DEPTH));
    // Read capture waits until the response buffer has (or is freeing) a slot.
    assign rsp_push  = (state == ST_CAPTURE) && (rw_out == RW_READ) && (!rsp_full || rsp_pop);

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_push),
        .wr_data (cmd_in),
        .rd_en   (cmd_pop),
        .rd_data (cmd_head),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rsp_push),
        .wr_data (m_rcvd_data),
        .rd_en   (rsp_pop),
        .rd_data (rsp_data),
        .empty   (rsp_empty),
        .count   (rsp_count)
    );

    // Transfer sequencing; start/busy/rw_out/m_data_out are all registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            start      <= 1'b0;
            busy       <= 1'b0;
            rw_out     <= 1'b0;
            m_data_out <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!cmd_empty) begin
                        state      <= ST_ISSUE;
                        start      <= 1'b1;
                        busy       <= 1'b1;
                        rw_out     <= cmd_head.rw;
                        m_data_out <= cmd_head.data;
                    end
                end
                ST_ISSUE: begin
                    cnt <= CNT_W'(XFER_CYCLES - 2);
                    if (XFER_CYCLES > 2) begin
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if ((rw_out == RW_WRITE) || rsp_push) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proto_sequencer.sv
// Directed bench for proto_sequencer: single writes/reads, back-pressure, stall and reset.
module tb_proto_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [3:0] cmd_data;
    logic       start;
    logic       rw_out;
    logic [3:0] m_data_out;
    logic [3:0] m_rcvd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;
    logic [2:0] cmd_count;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         start_q[$];
    logic [3:0] next_rsp = 4'h0;
    logic [3:0] exp5 [5] = '{4'h4, 4'h7, 4'hA, 4'hD, 4'h0};

    proto_sequencer #(
        .DEPTH       (4),
        .XFER_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_data    (cmd_data),
        .start       (start),
        .rw_out      (rw_out),
        .m_data_out  (m_data_out),
        .m_rcvd_data (m_rcvd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .cmd_count   (cmd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; the slave model returns a new read value on each start pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (start) begin
            start_q.push_back(cyc);
            m_rcvd_data = next_rsp;
            next_rsp    = next_rsp + 4'd3;
        end
    endtask

    task automatic send(input logic rw, input logic [3:0] d, output int acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_data  = d;
        while (!cmd_ready && n < 60) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            check_eq("send_ready", 32'(cmd_ready), 32'd1);
            acc = -1;
        end else begin
            tick();
            acc = cyc;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy == 1'b0 && cmd_count == 3'd0) && n < 300) begin
            tick();
            n++;
        end
        check_eq("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int acc0;
        int acc5;
        int dummy;
        int first;
        int n_start;
        int n_busy;
        int n_hold;
        int n_rsp;
        int k;
        int n;

        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_rw      = 1'b0;
        cmd_data    = 4'h0;
        m_rcvd_data = 4'h0;
        rsp_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_start",     32'(start),      32'd0);
        check_eq("rst_busy",      32'(busy),       32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready),  32'd1);
        check_eq("rst_cmd_count", 32'(cmd_count),  32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        check_eq("rst_rw_out",    32'(rw_out),     32'd0);
        check_eq("rst_m_data",    32'(m_data_out), 32'd0);
        rst = 1'b1;
        tick();

        // Single write of 4'hA
        send(1'b1, 4'hA, acc0);
        check_eq("wr_cmd_count", 32'(cmd_count), 32'd1);
        first = -1; n_start = 0; n_busy = 0; n_hold = 0; n_rsp = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (start) begin
                n_start++;
                if (first < 0) first = i;
            end
            if (busy) n_busy++;
            if (busy && rw_out == 1'b1 && m_data_out == 4'hA) n_hold++;
            if (rsp_valid) n_rsp++;
        end
        check_eq("wr_start_pos",   32'(first),   32'd1);
        check_eq("wr_start_width", 32'(n_start), 32'd1);
        check_eq("wr_busy_cycles", 32'(n_busy),  32'd8);
        check_eq("wr_hold_cycles", 32'(n_hold),  32'd8);
        check_eq("wr_no_rsp",      32'(n_rsp),   32'd0);
        check_eq("wr_data_kept",   32'(m_data_out), 32'hA);

        // Single read returning 4'h5
        next_rsp = 4'h5;
        send(1'b0, 4'h0, acc0);
        first = -1;
        n = 0;
        while (first < 0 && n < 30) begin
            tick();
            n++;
            if (rsp_valid) first = n;
        end
        check_eq("rd_rsp_pos",  32'(first),    32'd9);
        check_eq("rd_rsp_data", 32'(rsp_data), 32'h5);
        check_eq("rd_busy_off", 32'(busy),     32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("rd_rsp_clear", 32'(rsp_valid), 32'd0);
        wait_idle();

        // Back-to-back commands against the 4-deep command buffer
        start_q.delete();
        send(1'b1, 4'h0, acc0);
        send(1'b1, 4'h1, dummy);
        check_eq("b2b_push_pop_count", 32'(cmd_count), 32'd1);
        send(1'b1, 4'h2, dummy);
        send(1'b1, 4'h3, dummy);
        send(1'b1, 4'h4, dummy);
        check_eq("b2b_full_count", 32'(cmd_count), 32'd4);
        check_eq("b2b_ready_low",  32'(cmd_ready), 32'd0);
        send(1'b1, 4'h5, acc5);
        check_eq("b2b_fifth_accept", 32'(acc5 - acc0), 32'd11);
        n = 0;
        while (start_q.size() < 6 && n < 100) begin
            tick();
            n++;
        end
        check_eq("b2b_start_count", 32'(start_q.size()), 32'd6);
        if (start_q.size() > 0) begin
            check_eq("b2b_first_start", 32'(start_q[0] - acc0), 32'd1);
        end
        for (int i = 1; i < start_q.size(); i++) begin
            check_eq($sformatf("b2b_spacing_%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd9);
        end
        check_eq("b2b_last_data", 32'(m_data_out), 32'h5);
        wait_idle();

        // Response buffer back-pressure: fifth read stalls in capture
        next_rsp = 4'h1;
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 4'(i), dummy);
        end
        repeat (60) tick();
        check_eq("stall_starts",    32'(start_q.size()), 32'd5);
        check_eq("stall_busy",      32'(busy),           32'd1);
        check_eq("stall_cmd_count", 32'(cmd_count),      32'd1);
        check_eq("stall_rsp_valid", 32'(rsp_valid),      32'd1);
        check_eq("stall_rsp_head",  32'(rsp_data),       32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("stall_rsp_after_pulse", 32'(rsp_valid), 32'd1);
        k = 0;
        n = 0;
        rsp_ready = 1'b1;
        while (k < 5 && n < 100) begin
            if (rsp_valid) begin
                check_eq($sformatf("order_%0d", k), 32'(rsp_data), 32'(exp5[k]));
                k++;
            end
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        check_eq("order_count",  32'(k),              32'd5);
        check_eq("stall_starts6", 32'(start_q.size()), 32'd6);
        wait_idle();

        // Reset asserted while a write sits in WAIT
        next_rsp = 4'h9;
        send(1'b0, 4'h0, dummy);
        n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        check_eq("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        send(1'b1, 4'hF, acc0);
        send(1'b1, 4'h3, dummy);
        tick();
        tick();
        check_eq("pre_rst_busy",   32'(busy),       32'd1);
        check_eq("pre_rst_m_data", 32'(m_data_out), 32'hF);
        rst = 1'b0;
        #2;
        check_eq("arst_start",     32'(start),      32'd0);
        check_eq("arst_busy",      32'(busy),       32'd0);
        check_eq("arst_rw_out",    32'(rw_out),     32'd0);
        check_eq("arst_m_data",    32'(m_data_out), 32'd0);
        check_eq("arst_rsp_valid", 32'(rsp_valid),  32'd0);
        check_eq("arst_cmd_count", 32'(cmd_count),  32'd0);
        check_eq("arst_cmd_ready", 32'(cmd_ready),  32'd1);
        check_eq("arst_rsp_data",  32'(rsp_data),   32'd0);
        tick();
        rst = 1'b1;
        start_q.delete();
        repeat (30) tick();
        check_eq("post_rst_no_start", 32'(start_q.size()), 32'd0);
        check_eq("post_rst_idle",     32'(busy),           32'd0);
        send(1'b1, 4'h6, dummy);
        repeat (3) tick();
        check_eq("post_rst_new_start", 32'(start_q.size()), 32'd1);
        check_eq("post_rst_new_data",  32'(m_data_out),     32'h6);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/proto_sequencer.md
PROTO_SEQUENCER -- requirements
Module: proto_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command and response buffer depth (power of 2, minimum 2).
REQ-002 Parameter XFER_CYCLES, default 8, SHALL set the cycles reserved per transfer, counted from the start pulse (minimum 2).
REQ-003 clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  marks that a command is offered.
REQ-006 cmd_ready  out  1  marks that the command buffer can accept a command.
REQ-007 cmd_rw  in  1  is the command direction: 1 = write to slave, 0 = read from slave.
REQ-008 cmd_data  in  4  is the write data; it is ignored for reads.
REQ-009 start  out  1  is a single-cycle transfer start pulse to the master/slave top.
REQ-010 rw_out  out  1  drives the top's rw_in.
REQ-011 m_data_out  out  4  drives the top's m_data_in.
REQ-012 m_rcvd_data  in  4  is the read data returned by the top.
REQ-013 rsp_valid  out  1  marks that read data is available.
REQ-014 rsp_ready  in  1  is the consumer's acceptance of read data.
REQ-015 rsp_data  out  4  is the read data at the head of the response buffer.
REQ-016 busy  out  1  SHALL be high in every state other than IDLE.
REQ-017 cmd_count  out  $clog2(DEPTH)+1  SHALL report the command-buffer occupancy.

Function
REQ-018 A command SHALL be accepted on a cycle with cmd_valid and cmd_ready both high; cmd_ready SHALL equal "command buffer not full".
REQ-019 The FSM SHALL have four states:
- IDLE
- ISSUE
- WAIT
- CAPTURE
REQ-020 IDLE SHALL go to ISSUE on the cycle after the command buffer is non-empty, and SHALL pop the head command into the rw_out/m_data_out holding registers at that transition.
REQ-021 In ISSUE, start SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT with the counter loaded to XFER_CYCLES-2.
REQ-022 WAIT SHALL decrement the counter each cycle and SHALL go to CAPTURE when the counter reaches 0, so that ISSUE through CAPTURE spans XFER_CYCLES cycles.
REQ-023 For writes, CAPTURE SHALL return to IDLE after one cycle.
REQ-024 For reads, CAPTURE SHALL push m_rcvd_data into the response buffer, then return to IDLE.
REQ-025 If the response buffer is full, CAPTURE SHALL stall without sampling, sample m_rcvd_data on the first cycle with free space, then return to IDLE.
REQ-026 rw_out and m_data_out SHALL remain stable from ISSUE until the next command is popped.
REQ-027 Consecutive commands SHALL produce start pulses at least XFER_CYCLES+1 cycles apart.
REQ-028 A command push and a command pop in the same cycle SHALL leave cmd_count unchanged.
REQ-029 A response push and a response pop in the same cycle SHALL be legal when the response buffer is full.
REQ-030 Buffer pointers SHALL wrap modulo DEPTH, and full/empty SHALL be resolved with an extra pointer bit.
REQ-031 rsp_valid SHALL equal "response buffer not empty", and rsp_data SHALL show the head entry combinationally.
REQ-032 Responses SHALL be delivered in command order.

Reset
REQ-033 Asserting rst (low) SHALL immediately force:
- FSM to IDLE
- counter to 0
- start, rw_out, m_data_out, rsp_valid, busy and cmd_count to 0
- cmd_ready to 1
- both buffers empty
REQ-034 A reset mid-transfer SHALL discard the in-flight command and all queued commands and responses, with no start pulse issued.
REQ-035 Deassertion SHALL take effect on the next rising clk edge.

Structure
REQ-036 Package proto_pkg SHALL hold:
- the FSM state enum
- the constants RW_WRITE=1 and RW_READ=0
- DATA_W=4
REQ-037 A single sub-module, sync_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice:
- as the command buffer, WIDTH 5
- as the response buffer, WIDTH 4
REQ-038 The block SHALL sit directly upstream of top, with outputs wired to start, rw_in and m_data_in and m_rcvd_data taken from the top.

Verification
REQ-039 Write 4'hA, XFER_CYCLES=8 -> start high for 1 cycle two cycles after acceptance, with rw_out=1 and m_data_out=4'hA held for 8 cycles, busy high for 8 cycles, and no rsp_valid.
REQ-040 Read with m_rcvd_data=4'h5 -> rsp_valid rises one cycle after CAPTURE with rsp_data=4'h5; rsp_ready=1 clears it the next cycle.
REQ-041 Five back-to-back commands with DEPTH=4 -> cmd_ready low after 4 are accepted, the fifth is accepted after the first pop, and start pulses are spaced 9 cycles apart.
REQ-042 Five reads with rsp_ready held 0 -> the 5th transfer stalls in CAPTURE and no 6th start occurs; a rsp_ready pulse lets it complete with data in order.
REQ-043 rst asserted during WAIT -> all outputs are 0 asynchronously, and no further start pulse occurs after release until a new command arrives.
